ssd_display_arbiter: RTL

Shares the Nexys4 eight-digit seven-segment display between two requesters: a persistent base source (score, debug values) and a transient message source (e.g. "LOSE", level banners) that preempts the base for a fixed number of scan frames. It owns the digit scan timing, the per-slot anode blanking (anti-ghosting), the message request/acknowledge handshake and the hex-to-segment conversion. It sits between the game logic and the An0..An7 / Ca..Cg, Dp board pins.

---
 rtl/ssd_display_arbiter_if.sv | 26 ++
 rtl/ssd_display_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ssd_display_arbiter_if.sv
// Display arbiter bus: base/message requester side (master) and arbiter side (slave).
// Carries source data, message handshake and the registered board-pin outputs.
interface ssd_display_arbiter_if;
  logic [31:0] base_val;
  logic [7:0]  base_en;
  logic [7:0]  base_dp;
  logic        msg_req;
  logic [31:0] msg_val;
  logic [7:0]  msg_en;
  logic [7:0]  msg_dp;
  logic        msg_ack;
  logic        msg_busy;
  logic        src;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport master (
    output base_val, base_en, base_dp, msg_req, msg_val, msg_en, msg_dp,
    input  msg_ack, msg_busy, src, an, seg
  );

  modport slave (
    input  base_val, base_en, base_dp, msg_req, msg_val, msg_en, msg_dp,
    output msg_ack, msg_busy, src, an, seg
  );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Eight-digit seven-segment scan with base/message source arbitration; all outputs registered.
// Optional SSD_ARB_PREEMPT_EN: a new message request while busy re-latches data and restarts the hold.
module ssd_display_arbiter #(
  parameter int SLOT_W       = 18,
  parameter int BLANK_CYCLES = 1024,
  parameter int HOLD_FRAMES  = 64
) (
  input  logic                 ClkPort,
  input  logic                 Reset,
  ssd_display_arbiter_if.slave io
);
  typedef enum logic [1:0] {ST_BASE, ST_PENDING, ST_SHOW} state_t;

  localparam logic [SLOT_W-1:0] SLOT_LAST = '1;
  localparam logic [SLOT_W-1:0] BLANK     = SLOT_W'(BLANK_CYCLES);
  localparam logic [7:0]        HOLD      = 8'(HOLD_FRAMES);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [2:0]        digit_q, digit_d;
  logic [7:0]        hold_q, hold_d;
  logic              reload_q, reload_d;
  logic [31:0]       mval_q, mval_d;
  logic [7:0]        men_q, men_d;
  logic [7:0]        mdp_q, mdp_d;
  logic              en_snap_q, en_snap_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              src_q, src_d;

  logic              frame_end, accept, en_cur;
  logic [31:0]       act_val;
  logic [7:0]        act_en, act_dp;
  logic [3:0]        nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    frame_end = (slot_q == SLOT_LAST) && (digit_q == 3'd7);
    slot_d    = slot_q + 1'b1;
    digit_d   = (slot_q == SLOT_LAST) ? digit_q + 3'd1 : digit_q;

    // src_q only changes at frame boundaries, so selecting on it keeps a frame single-source.
    act_val = src_q ? mval_q : io.base_val;
    act_en  = src_q ? men_q  : io.base_en;
    act_dp  = src_q ? mdp_q  : io.base_dp;
    nib     = act_val[{digit_q, 2'b00} +: 4];

    en_snap_d = en_snap_q;
    seg_d     = seg_q;
    if (slot_q == '0) begin
      en_snap_d = act_en[digit_q];
      seg_d     = act_en[digit_q] ? {hex7(nib), ~act_dp[digit_q]} : 8'hFF;
    end

    // Anode stays low one cycle into the next slot, where seg still holds this digit.
    en_cur = (slot_q == '0) ? act_en[digit_q] : en_snap_q;
    an_d   = 8'hFF;
    if (slot_q >= BLANK && en_cur) an_d = ~(8'd1 << digit_q);

    state_d  = state_q;
    hold_d   = hold_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    src_d    = src_q;
    ack_d    = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_BASE: if (io.msg_req) begin
        accept  = 1'b1;
        busy_d  = 1'b1;
        state_d = ST_PENDING;
      end
      ST_PENDING: if (frame_end) begin
        hold_d  = HOLD;
        src_d   = 1'b1;
        state_d = ST_SHOW;
      end
      ST_SHOW: if (frame_end) begin
        if (reload_q) begin
          hold_d   = HOLD;
          reload_d = 1'b0;
        end else if (hold_q == 8'd1) begin
          hold_d  = 8'd0;
          src_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_BASE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = ST_BASE;
    endcase

`ifdef SSD_ARB_PREEMPT_EN
    if (state_q != ST_BASE && io.msg_req && !ack_q) begin
      accept = 1'b1;
      if (state_q == ST_SHOW) begin
        if (frame_end) begin
          hold_d   = HOLD;
          reload_d = 1'b0;
          src_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_SHOW;
        end else begin
          reload_d = 1'b1;
        end
      end
    end
`endif

    mval_d = mval_q;
    men_d  = men_q;
    mdp_d  = mdp_q;
    if (accept) begin
      ack_d  = 1'b1;
      mval_d = io.msg_val;
      men_d  = io.msg_en;
      mdp_d  = io.msg_dp;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_BASE;
      slot_q    <= '0;
      digit_q   <= 3'd0;
      hold_q    <= 8'd0;
      reload_q  <= 1'b0;
      mval_q    <= 32'd0;
      men_q     <= 8'd0;
      mdp_q     <= 8'd0;
      en_snap_q <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 8'hFF;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      src_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      digit_q   <= digit_d;
      hold_q    <= hold_d;
      reload_q  <= reload_d;
      mval_q    <= mval_d;
      men_q     <= men_d;
      mdp_q     <= mdp_d;
      en_snap_q <= en_snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      src_q     <= src_d;
    end
  end

  assign io.an       = an_q;
  assign io.seg      = seg_q;
  assign io.msg_ack  = ack_q;
  assign io.msg_busy = busy_q;
  assign io.src      = src_q;
endmodule
